// File: rtl/regfile_scoreboard_if.sv
// Operand-read, destination-claim and writeback signal bundle for regfile_scoreboard.
// The master side drives indices, claims and writebacks; the slave (scoreboard) answers.
interface regfile_scoreboard_if #(
    parameter int NREGS  = 32,
    parameter int WIDTH  = 64,
    parameter int RPORTS = 3,
    parameter int CPORTS = 2,
    parameter int WPORTS = 2
);
    localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [IW-1:0]    rd_idx      [RPORTS];
    logic [WIDTH-1:0] rd_data     [RPORTS];
    logic             rd_busy     [RPORTS];

    logic             claim_valid [CPORTS];
    logic [IW-1:0]    claim_idx   [CPORTS];
    logic             claim_stall;

    logic             wb_valid    [WPORTS];
    logic [IW-1:0]    wb_idx      [WPORTS];
    logic [WIDTH-1:0] wb_data     [WPORTS];
    logic             wb_release  [WPORTS];

    logic             flush;
    logic             any_pending;
    logic             err_underflow;

    modport master (
        output rd_idx, claim_valid, claim_idx, wb_valid, wb_idx, wb_data, wb_release, flush,
        input  rd_data, rd_busy, claim_stall, any_pending, err_underflow
    );

    modport slave (
        input  rd_idx, claim_valid, claim_idx, wb_valid, wb_idx, wb_data, wb_release, flush,
        output rd_data, rd_busy, claim_stall, any_pending, err_underflow
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Multi-ported register file with per-register in-flight writer counters.
// Reads bypass same-cycle writebacks; claims are accepted all-or-nothing against a saturating count.
module regfile_scoreboard #(
    parameter int NREGS    = 32,
    parameter int WIDTH    = 64,
    parameter int RPORTS   = 3,
    parameter int CPORTS   = 2,
    parameter int WPORTS   = 2,
    parameter int CNT_W    = 2,
    parameter int RSP_IDX  = 7,
    parameter logic [WIDTH-1:0] RSP_INIT = 64'h7C00
) (
    input  logic               clk,
    input  logic               reset,
    regfile_scoreboard_if.slave bus
);
    localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;
    // Sums of count plus per-cycle claims/releases need headroom beyond CNT_W.
    localparam int SW = CNT_W + $clog2(CPORTS + WPORTS + 1) + 1;
    localparam logic [SW-1:0] MAXC = SW'((1 << CNT_W) - 1);

    logic [WIDTH-1:0] array_q [NREGS];
    logic [WIDTH-1:0] array_d [NREGS];
    logic [CNT_W-1:0] count_q [NREGS];
    logic [CNT_W-1:0] count_d [NREGS];
    logic             err_q;
    logic             err_d;

    logic [SW-1:0]    clm_cnt [NREGS];
    logic [SW-1:0]    rel_cnt [NREGS];
    logic             stall_raw;

    function automatic logic in_range(input logic [IW-1:0] idx);
        return ({1'b0, idx} < (IW+1)'(NREGS));
    endfunction

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            clm_cnt[r] = '0;
            rel_cnt[r] = '0;
        end
        for (int c = 0; c < CPORTS; c++) begin
            if (bus.claim_valid[c] && in_range(bus.claim_idx[c])) begin
                clm_cnt[bus.claim_idx[c]] = clm_cnt[bus.claim_idx[c]] + SW'(1);
            end
        end
        for (int w = 0; w < WPORTS; w++) begin
            if (bus.wb_valid[w] && bus.wb_release[w] && in_range(bus.wb_idx[w])) begin
                rel_cnt[bus.wb_idx[w]] = rel_cnt[bus.wb_idx[w]] + SW'(1);
            end
        end
    end

    // Releases are deliberately not credited here: a claim must fit on top of today's count.
    always_comb begin
        stall_raw = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            if ((clm_cnt[r] != '0) && ((SW'(count_q[r]) + clm_cnt[r]) > MAXC)) begin
                stall_raw = 1'b1;
            end
        end
    end

    assign bus.claim_stall = stall_raw & ~bus.flush;

    always_comb begin
        logic          uflow;
        logic [SW-1:0] rel_app;
        logic [SW-1:0] clm_app;
        uflow   = 1'b0;
        rel_app = '0;
        clm_app = '0;
        for (int r = 0; r < NREGS; r++) begin
            if (bus.flush) begin
                count_d[r] = '0;
            end else begin
                // Releases beyond the current count are dropped and flagged.
                if (rel_cnt[r] > SW'(count_q[r])) begin
                    rel_app = SW'(count_q[r]);
                    uflow   = 1'b1;
                end else begin
                    rel_app = rel_cnt[r];
                end
                clm_app    = stall_raw ? '0 : clm_cnt[r];
                count_d[r] = CNT_W'(SW'(count_q[r]) - rel_app + clm_app);
            end
        end
        err_d = err_q | uflow;
    end

    always_comb begin
        array_d = array_q;
        for (int w = 0; w < WPORTS; w++) begin
            if (bus.wb_valid[w] && in_range(bus.wb_idx[w])) begin
                array_d[bus.wb_idx[w]] = bus.wb_data[w];
            end
        end
    end

    // Later wb ports override earlier ones in the bypass, matching the write priority.
    always_comb begin
        for (int p = 0; p < RPORTS; p++) begin
            if (in_range(bus.rd_idx[p])) begin
                bus.rd_data[p] = array_q[bus.rd_idx[p]];
                bus.rd_busy[p] = SW'(count_q[bus.rd_idx[p]]) > rel_cnt[bus.rd_idx[p]];
            end else begin
                bus.rd_data[p] = '0;
                bus.rd_busy[p] = 1'b0;
            end
            for (int w = 0; w < WPORTS; w++) begin
                if (bus.wb_valid[w] && in_range(bus.wb_idx[w]) && (bus.wb_idx[w] == bus.rd_idx[p])) begin
                    bus.rd_data[p] = bus.wb_data[w];
                end
            end
        end
    end

    always_comb begin
        bus.any_pending = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            if (count_q[r] != '0) begin
                bus.any_pending = 1'b1;
            end
        end
    end

    assign bus.err_underflow = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                array_q[r] <= (r == RSP_IDX) ? RSP_INIT : '0;
                count_q[r] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            array_q <= array_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: stimulus pushes expected outputs into a queue,
// a negedge monitor pops and compares them against the live DUT outputs.
module tb_regfile_scoreboard;
    localparam int NREGS  = 32;
    localparam int WIDTH  = 64;
    localparam int RPORTS = 3;
    localparam int CPORTS = 2;
    localparam int WPORTS = 2;

    localparam int K_DATA  = 0;
    localparam int K_BUSY  = 1;
    localparam int K_STALL = 2;
    localparam int K_PEND  = 3;
    localparam int K_ERR   = 4;

    typedef struct {
        string       name;
        int          kind;
        int          port;
        logic [63:0] exp;
    } exp_t;

    logic clk;
    logic reset;
    exp_t sb_q[$];
    int   n_checks;
    int   n_fail;

    regfile_scoreboard_if #(
        .NREGS(NREGS), .WIDTH(WIDTH), .RPORTS(RPORTS), .CPORTS(CPORTS), .WPORTS(WPORTS)
    ) bus ();

    regfile_scoreboard dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        for (int c = 0; c < CPORTS; c++) begin
            bus.claim_valid[c] = 1'b0;
            bus.claim_idx[c]   = '0;
        end
        for (int w = 0; w < WPORTS; w++) begin
            bus.wb_valid[w]   = 1'b0;
            bus.wb_idx[w]     = '0;
            bus.wb_data[w]    = '0;
            bus.wb_release[w] = 1'b0;
        end
        bus.flush = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic expect_out(input string name, input int kind, input int port, input logic [63:0] exp);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.port = port;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic claim(input int port, input int idx);
        bus.claim_valid[port] = 1'b1;
        bus.claim_idx[port]   = 5'(idx);
    endtask

    task automatic wb(input int port, input int idx, input logic [63:0] data, input logic rel);
        bus.wb_valid[port]   = 1'b1;
        bus.wb_idx[port]     = 5'(idx);
        bus.wb_data[port]    = data;
        bus.wb_release[port] = rel;
    endtask

    // Monitor: every queued expectation refers to the outputs of the current cycle.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t        e;
            logic [63:0] act;
            e = sb_q.pop_front();
            case (e.kind)
                K_DATA:  act = bus.rd_data[e.port];
                K_BUSY:  act = {63'd0, bus.rd_busy[e.port]};
                K_STALL: act = {63'd0, bus.claim_stall};
                K_PEND:  act = {63'd0, bus.any_pending};
                default: act = {63'd0, bus.err_underflow};
            endcase
            n_checks++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        idle();
        for (int p = 0; p < RPORTS; p++) bus.rd_idx[p] = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Post-reset state
        bus.rd_idx[0] = 5'd7;
        bus.rd_idx[1] = 5'd3;
        expect_out("reset_rsp_data", K_DATA, 0, 64'h7C00);
        expect_out("reset_rsp_busy", K_BUSY, 0, 64'd0);
        expect_out("reset_r3_data", K_DATA, 1, 64'd0);
        expect_out("reset_pending", K_PEND, 0, 64'd0);
        expect_out("reset_err", K_ERR, 0, 64'd0);
        expect_out("reset_stall", K_STALL, 0, 64'd0);

        // Two claims to r3, then two releasing writebacks
        step(); claim(0, 3); bus.rd_idx[0] = 5'd3;
        expect_out("c3a_stall", K_STALL, 0, 64'd0);
        expect_out("c3a_busy_excl_claim", K_BUSY, 0, 64'd0);
        step(); claim(0, 3);
        expect_out("c3b_busy", K_BUSY, 0, 64'd1);
        expect_out("c3b_pending", K_PEND, 0, 64'd1);
        step(); wb(0, 3, 64'hAB, 1'b1);
        expect_out("wb3a_busy", K_BUSY, 0, 64'd1);
        expect_out("wb3a_bypass", K_DATA, 0, 64'hAB);
        step(); wb(0, 3, 64'hAB, 1'b1);
        expect_out("wb3b_busy", K_BUSY, 0, 64'd0);
        step();
        expect_out("r3_data", K_DATA, 0, 64'hAB);
        expect_out("r3_busy", K_BUSY, 0, 64'd0);
        expect_out("r3_pending", K_PEND, 0, 64'd0);

        // Fill r5 to MAXC, then an over-full claim pair stalls as a whole
        step(); claim(0, 5); claim(1, 5); bus.rd_idx[0] = 5'd5;
        expect_out("c5x2_stall", K_STALL, 0, 64'd0);
        step(); claim(0, 5);
        expect_out("c5c_stall", K_STALL, 0, 64'd0);
        expect_out("c5c_busy", K_BUSY, 0, 64'd1);
        step(); claim(0, 5); claim(1, 6); bus.rd_idx[1] = 5'd6;
        expect_out("full_stall", K_STALL, 0, 64'd1);
        step(); claim(0, 5);
        expect_out("r6_not_claimed", K_BUSY, 1, 64'd0);
        expect_out("r5_still_busy", K_BUSY, 0, 64'd1);
        expect_out("r5_still_full", K_STALL, 0, 64'd1);

        // Both wb ports to r2: port 1 wins
        step(); wb(0, 2, 64'h11, 1'b0); wb(1, 2, 64'h22, 1'b0); bus.rd_idx[2] = 5'd2;
        expect_out("wb2_bypass", K_DATA, 2, 64'h22);
        step();
        expect_out("wb2_stored", K_DATA, 2, 64'h22);

        // Flush with a colliding claim and a releasing writeback
        step(); bus.flush = 1'b1; claim(0, 4); claim(1, 5); wb(0, 4, 64'h5, 1'b1);
        expect_out("flush_stall", K_STALL, 0, 64'd0);
        expect_out("flush_pend_before", K_PEND, 0, 64'd1);
        step(); bus.rd_idx[0] = 5'd4; bus.rd_idx[1] = 5'd5;
        expect_out("flush_pend_after", K_PEND, 0, 64'd0);
        expect_out("flush_r4_data", K_DATA, 0, 64'h5);
        expect_out("flush_r4_busy", K_BUSY, 0, 64'd0);
        expect_out("flush_r5_busy", K_BUSY, 1, 64'd0);
        expect_out("flush_no_err", K_ERR, 0, 64'd0);

        // Underflowing release to r9
        step(); wb(1, 9, 64'h99, 1'b1); bus.rd_idx[0] = 5'd9;
        expect_out("uf_busy", K_BUSY, 0, 64'd0);
        expect_out("uf_err_before", K_ERR, 0, 64'd0);
        step();
        expect_out("uf_err_set", K_ERR, 0, 64'd1);
        expect_out("uf_count_zero", K_PEND, 0, 64'd0);
        expect_out("uf_r9_data", K_DATA, 0, 64'h99);
        step(); claim(0, 9);
        expect_out("uf_err_sticky", K_ERR, 0, 64'd1);
        expect_out("uf_claim_ok", K_STALL, 0, 64'd0);

        // Reset clears the sticky error and restores the array
        step(); reset = 1'b1;
        step(); reset = 1'b0;
        bus.rd_idx[0] = 5'd7; bus.rd_idx[1] = 5'd2; bus.rd_idx[2] = 5'd9;
        expect_out("rst2_err", K_ERR, 0, 64'd0);
        expect_out("rst2_rsp", K_DATA, 0, 64'h7C00);
        expect_out("rst2_r2", K_DATA, 1, 64'd0);
        expect_out("rst2_r9", K_DATA, 2, 64'd0);
        expect_out("rst2_pending", K_PEND, 0, 64'd0);

        begin
            int waited;
            waited = 0;
            while (sb_q.size() > 0 && waited < 10) begin
                @(posedge clk);
                waited++;
            end
            if (sb_q.size() > 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
